inst_encoder: RTL and testbench
===============================

# inst_encoder

Inverse of the ID-stage decoder. Accepts RV32I instruction fields (format kind, register indices, funct3, bit-30 alternate, full 32-bit immediate) over a valid/ready handshake. Packs each into a 32-bit machine word, buffers it in a small FIFO and streams it into instruction memory at consecutive word addresses. Used by the boot/self-test loader to build programs for the pipeline without an external assembler.

## Interface
- `ADDR_W`, 10: instruction-memory word-address width.
- `DEPTH`, 4: encoded-word FIFO depth (power of two, ≥2).
- `BASE_ADDR`, 0: first word address written after `start`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begin a program; honoured only in IDLE.
- `in_valid`  in  1  field bundle valid.
- `in_ready`  out  1  bundle accepted when `in_valid & in_ready`.
- `in_kind`  in  4  format kind: R, I, LW, SW, SB, JAL, JALR, LUI, AUIPC.
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register indices.
- `in_funct3`  in  3  funct3 for R/I/SB kinds.
- `in_alt`  in  1  instruction bit 30 (SUB/SRA/SRAI).
- `in_imm`  in  32  signed byte offset or immediate value.
- `in_last`  in  1  marks final bundle of the program.
- `imem_we`  out  1  write request.
- `imem_ready`  in  1  memory accepts write when `imem_we & imem_ready`.
- `imem_addr`  out  ADDR_W  word address.
- `imem_wdata`  out  32  encoded instruction.
- `done`  out  1  one-cycle pulse, program fully written.
- `err_imm`  out  1  sticky: immediate unrepresentable or illegal kind.
- `err_wrap`  out  1  sticky: address wrapped past 2^ADDR_W−1.
- `count`  out  ADDR_W+1  words written since `start`.

## Operation
- Opcodes: R 0110011, I 0010011, LW 0000011, SW 0100011, SB 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
- LW and SW force funct3=010. JALR forces funct3=000.
- Unused register fields for a kind are encoded as 0.
- I kind with funct3 1 or 5 (shift):
  - bits[24:20]=`in_imm[4:0]`, bits[31:25]={0,`in_alt`,00000}.
  - `in_imm[31:5]`≠0 → error.
- Other I kinds, LW, JALR, SW: imm must lie in [−2048,2047].
- SB: imm even, in [−4096,4094].
- JAL: imm even, in [−2^20, 2^20−2].
- LUI/AUIPC: `in_imm[11:0]` must be 0; encode `in_imm[31:12]`.
- Range violation or undefined kind:
  - The word 0x00000013 (NOP) is written instead.
  - `err_imm` is set.
- FSM states:
  - IDLE: `in_ready`=0. `start` → RUN; loads addr=BASE_ADDR, clears `count`, `err_imm`, `err_wrap`.
  - RUN: `in_ready`=!full. Accepting a bundle with `in_last`=1 → DRAIN.
  - DRAIN: `in_ready`=0. FIFO empty and no write pending → DONE.
  - DONE: `done`=1 for exactly one cycle → IDLE.
- `imem_we` = FIFO non-empty, in RUN or DRAIN.
- On each accepted write: addr+1 modulo 2^ADDR_W, `count`+1.
- Wrap from all-ones to 0 sets `err_wrap`. Writing continues.
- `start` outside IDLE is ignored.
- Push while full cannot occur (`in_ready` low).
- Push and pop in the same cycle are both performed; occupancy is unchanged.

## Timing
- Reset values: `in_ready`=0, `imem_we`=0, `imem_addr`=BASE_ADDR, `imem_wdata`=0, `done`=0, `err_imm`=0, `err_wrap`=0, `count`=0. FSM goes to IDLE and the FIFO is emptied.
- Encoding is combinational at the input. The word is registered into the FIFO on accept.
- Accept at edge N → `imem_we` high with that word from cycle N+1 (empty FIFO).
- Sustained throughput is one word per cycle while `imem_ready`=1.
- `imem_addr`/`imem_wdata` hold stable while `imem_we`=1 and `imem_ready`=0.
- `done` rises the cycle after the final write handshake.
- Reset mid-program: all pending words are discarded; no write occurs after the reset edge.

## Structure
- Shared package `riscv_pkg` holds:
  - kind enumeration (4-bit);
  - the nine opcode constants;
  - funct3 constants for LW/SW/JALR;
  - NOP constant.
- Sub-module `inst_pack`: purely combinational fields→word plus error flag.
- The top level holds the FSM, FIFO pointers, address counter and sticky flags.

## Test plan
- add x3,x1,x2 (R, f3 0, alt 0) → `imem_wdata`=0x002081B3 at addr 0, one cycle after accept.
- srai x5,x6,3 (I, f3 5, alt 1) → 0x40335293. sw x2,8(x1) → 0x0020A423.
- beq x1,x2,−8 → 0xFE208CE3. jal x1,2048 → 0x001000EF.
- addi, imm 4096 → 0x00000013 written, `err_imm`=1, held until next `start`.
- DEPTH=4, 6 bundles back-to-back, `imem_ready` low cycles 1–3:
  - `in_ready` drops once 4 words are buffered;
  - addresses 0..5 in order, no loss;
  - `count`=6, `done` pulses once.
- Reset asserted in DRAIN with 2 words buffered → next cycle `imem_we`=0 and state is IDLE. `ADDR_W`=2, 5 words → `err_wrap`=1, fifth word at addr 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants, kind enumeration and field bundle type.
package riscv_pkg;

  typedef enum logic [3:0] {
    KIND_R     = 4'd0,
    KIND_I     = 4'd1,
    KIND_LW    = 4'd2,
    KIND_SW    = 4'd3,
    KIND_SB    = 4'd4,
    KIND_JAL   = 4'd5,
    KIND_JALR  = 4'd6,
    KIND_LUI   = 4'd7,
    KIND_AUIPC = 4'd8
  } kind_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_SB    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // One instruction's worth of fields as presented at the input handshake.
  typedef struct packed {
    kind_e       kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        alt;
    logic [31:0] imm;
  } fields_t;

endpackage

// File: rtl/inst_pack.sv
// Combinational RV32I packer: field bundle -> 32-bit machine word.
// Ports: fields_i (bundle), word_o (encoded word, NOP on error),
//        err_o (immediate unrepresentable or kind undefined).
module inst_pack
  import riscv_pkg::*;
(
  input  fields_t     fields_i,
  output logic [31:0] word_o,
  output logic        err_o
);

  logic [31:0] word;
  logic        err;
  logic        imm12_ok;
  logic        sb_ok;
  logic        jal_ok;
  logic        upper_ok;

  // Range checks: upper bits must be a pure sign extension.
  assign imm12_ok = (fields_i.imm[31:11] == {21{fields_i.imm[11]}});
  assign sb_ok    = (fields_i.imm[31:12] == {20{fields_i.imm[12]}}) && !fields_i.imm[0];
  assign jal_ok   = (fields_i.imm[31:20] == {12{fields_i.imm[20]}}) && !fields_i.imm[0];
  assign upper_ok = (fields_i.imm[11:0] == 12'd0);

  // Field placement per kind; unused register fields stay zero.
  always_comb begin
    word = NOP_WORD;
    err  = 1'b0;
    case (fields_i.kind)
      KIND_R: word = {1'b0, fields_i.alt, 5'b0, fields_i.rs2, fields_i.rs1,
                      fields_i.funct3, fields_i.rd, OP_R};
      KIND_I: begin
        if (fields_i.funct3 == 3'd1 || fields_i.funct3 == 3'd5) begin
          word = {1'b0, fields_i.alt, 5'b0, fields_i.imm[4:0], fields_i.rs1,
                  fields_i.funct3, fields_i.rd, OP_I};
          err  = |fields_i.imm[31:5];
        end else begin
          word = {fields_i.imm[11:0], fields_i.rs1, fields_i.funct3, fields_i.rd, OP_I};
          err  = !imm12_ok;
        end
      end
      KIND_LW: begin
        word = {fields_i.imm[11:0], fields_i.rs1, F3_LW, fields_i.rd, OP_LW};
        err  = !imm12_ok;
      end
      KIND_SW: begin
        word = {fields_i.imm[11:5], fields_i.rs2, fields_i.rs1, F3_SW,
                fields_i.imm[4:0], OP_SW};
        err  = !imm12_ok;
      end
      KIND_SB: begin
        word = {fields_i.imm[12], fields_i.imm[10:5], fields_i.rs2, fields_i.rs1,
                fields_i.funct3, fields_i.imm[4:1], fields_i.imm[11], OP_SB};
        err  = !sb_ok;
      end
      KIND_JAL: begin
        word = {fields_i.imm[20], fields_i.imm[10:1], fields_i.imm[11],
                fields_i.imm[19:12], fields_i.rd, OP_JAL};
        err  = !jal_ok;
      end
      KIND_JALR: begin
        word = {fields_i.imm[11:0], fields_i.rs1, F3_JALR, fields_i.rd, OP_JALR};
        err  = !imm12_ok;
      end
      KIND_LUI: begin
        word = {fields_i.imm[31:12], fields_i.rd, OP_LUI};
        err  = !upper_ok;
      end
      KIND_AUIPC: begin
        word = {fields_i.imm[31:12], fields_i.rd, OP_AUIPC};
        err  = !upper_ok;
      end
      default: err = 1'b1;
    endcase
  end

  assign word_o = err ? NOP_WORD : word;
  assign err_o  = err;

endmodule

// File: rtl/inst_encoder.sv
// Field-bundle to instruction-memory loader: encodes each accepted bundle,
// buffers it in a DEPTH-entry FIFO and writes it at consecutive addresses.
// Ports: clk/reset; start; in_* bundle handshake; imem_* write port;
//        done (one-cycle pulse), err_imm/err_wrap (sticky), count (words written).
module inst_encoder
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic              in_alt,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic              err_imm,
  output logic              err_wrap,
  output logic [ADDR_W:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned PW    = PTR_W + 1;
  localparam int unsigned CW    = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              err_imm_q, err_imm_d, err_wrap_q, err_wrap_d;
  logic              in_ready_q, in_ready_d, imem_we_q, imem_we_d, done_q, done_d;
  logic [31:0]       wdata_q, wdata_d;

  fields_t           fields;
  logic [31:0]       pack_word;
  logic              pack_err;
  logic              push, pop, empty_d, full_d;

  assign fields = '{kind: kind_e'(in_kind), rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                    funct3: in_funct3, alt: in_alt, imm: in_imm};

  inst_pack u_pack (
    .fields_i (fields),
    .word_o   (pack_word),
    .err_o    (pack_err)
  );

  // Next-state: FSM, FIFO pointers, address/count, sticky flags, registered outputs.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    err_imm_d  = err_imm_q;
    err_wrap_d = err_wrap_q;
    push       = in_valid & in_ready_q;
    pop        = imem_we_q & imem_ready;
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);

    if (pop) begin
      addr_d  = addr_q + ADDR_W'(1);
      count_d = count_q + CW'(1);
      if (&addr_q) err_wrap_d = 1'b1;
    end
    if (push && pack_err) err_imm_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          addr_d     = ADDR_W'(BASE_ADDR);
          count_d    = '0;
          err_imm_d  = 1'b0;
          err_wrap_d = 1'b0;
        end
      end
      S_RUN:   if (push && in_last) state_d = S_DRAIN;
      S_DRAIN: if (rd_ptr_d == wr_ptr_d) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    empty_d    = (wr_ptr_d == rd_ptr_d);
    full_d     = (wr_ptr_d[PTR_W] != rd_ptr_d[PTR_W]) &&
                 (wr_ptr_d[PTR_W-1:0] == rd_ptr_d[PTR_W-1:0]);
    in_ready_d = (state_d == S_RUN) && !full_d;
    imem_we_d  = (state_d == S_RUN || state_d == S_DRAIN) && !empty_d;
    done_d     = (state_d == S_DONE);
    // Head of FIFO after this edge; bypass the incoming word when it lands at the head.
    wdata_d    = (push && wr_ptr_q[PTR_W-1:0] == rd_ptr_d[PTR_W-1:0]) ?
                 pack_word : mem_q[rd_ptr_d[PTR_W-1:0]];
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      addr_q     <= ADDR_W'(BASE_ADDR);
      count_q    <= '0;
      err_imm_q  <= 1'b0;
      err_wrap_q <= 1'b0;
      in_ready_q <= 1'b0;
      imem_we_q  <= 1'b0;
      done_q     <= 1'b0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      err_imm_q  <= err_imm_d;
      err_wrap_q <= err_wrap_d;
      in_ready_q <= in_ready_d;
      imem_we_q  <= imem_we_d;
      done_q     <= done_d;
      wdata_q    <= wdata_d;
    end
  end

  // FIFO storage; stale entries are harmless because pointers gate use.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= pack_word;
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign done       = done_q;
  assign err_imm    = err_imm_q;
  assign err_wrap   = err_wrap_q;
  assign count      = count_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: behavioural model of the encoder and
// write stream compared every cycle, plus hand-computed instruction words.
module tb_inst_encoder;

  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset, start, in_valid, in_ready, in_alt, in_last;
  logic [3:0]    in_kind;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [2:0]    in_funct3;
  logic [31:0]   in_imm;
  logic          imem_we, imem_ready, done, err_imm, err_wrap;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;

  inst_encoder #(.ADDR_W(AW), .DEPTH(DEPTH), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_alt(in_alt), .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .done(done), .err_imm(err_imm), .err_wrap(err_wrap),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        alt;
    logic [31:0] imm;
  } bnd_t;

  int          total = 0;
  int          bad   = 0;
  bnd_t        prog_q[$];
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  int          rdy_mode = 0;
  int          rdy_hold = 0;
  int          done_cnt = 0;
  int          stall_cyc = 0;

  // Model: 0 idle, 1 run, 2 drain, 3 done.
  bit          m_valid = 0;
  int          m_phase;
  logic [31:0] m_q[$];
  int unsigned m_addr, m_count;
  bit          m_eimm, m_ewrap;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference encoding computed from the instruction-format rules.
  function automatic logic [31:0] enc(input logic [3:0] k, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic alt, input logic [31:0] imm, output bit err);
    int s;
    logic [31:0] w, d, r1, r2, f, a;
    s = $signed(imm);
    d = 32'(rd) << 7; r1 = 32'(rs1) << 15; r2 = 32'(rs2) << 20;
    f = 32'(f3) << 12; a = 32'(alt) << 30;
    err = 0; w = 0;
    case (k)
      4'd0: w = a | r2 | r1 | f | d | 32'h33;
      4'd1: if (f3 == 3'd1 || f3 == 3'd5) begin
              err = (imm >> 5) != 0;
              w = a | ((imm & 32'h1F) << 20) | r1 | f | d | 32'h13;
            end else begin
              err = s < -2048 || s > 2047;
              w = ((imm & 32'hFFF) << 20) | r1 | f | d | 32'h13;
            end
      4'd2: begin err = s < -2048 || s > 2047;
              w = ((imm & 32'hFFF) << 20) | r1 | (32'd2 << 12) | d | 32'h03; end
      4'd3: begin err = s < -2048 || s > 2047;
              w = (((imm >> 5) & 32'h7F) << 25) | r2 | r1 | (32'd2 << 12) |
                  ((imm & 32'h1F) << 7) | 32'h23; end
      4'd4: begin err = s < -4096 || s > 4094 || imm[0];
              w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | r2 | r1 | f |
                  (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | 32'h63; end
      4'd5: begin err = s < -1048576 || s > 1048574 || imm[0];
              w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                  (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | d | 32'h6F; end
      4'd6: begin err = s < -2048 || s > 2047;
              w = ((imm & 32'hFFF) << 20) | r1 | d | 32'h67; end
      4'd7: begin err = (imm & 32'hFFF) != 0; w = (imm & 32'hFFFFF000) | d | 32'h37; end
      4'd8: begin err = (imm & 32'hFFF) != 0; w = (imm & 32'hFFFFF000) | d | 32'h17; end
      default: err = 1;
    endcase
    if (err) w = 32'h13;
    return w;
  endfunction

  function automatic logic [31:0] enc_b(input bnd_t b);
    bit e;
    return enc(b.kind, b.rd, b.rs1, b.rs2, b.f3, b.alt, b.imm, e);
  endfunction

  // Per-cycle compare against the model, then advance the model over the next edge.
  task automatic mon();
    bit rdy_e, we_e, pop, push, e;
    logic [31:0] w;
    rdy_e = (m_phase == 1) && (m_q.size() < DEPTH);
    we_e  = (m_phase == 1 || m_phase == 2) && (m_q.size() > 0);
    if (m_valid) begin
      chk("in_ready", in_ready, rdy_e);
      chk("imem_we", imem_we, we_e);
      chk("done", done, m_phase == 3);
      chk("err_imm", err_imm, m_eimm);
      chk("err_wrap", err_wrap, m_ewrap);
      chk("count", count, m_count);
      if (we_e) begin
        chk("imem_addr", imem_addr, m_addr);
        chk("imem_wdata", imem_wdata, m_q[0]);
      end
    end
    if (done) done_cnt++;
    if (reset) begin
      m_valid = 1; m_phase = 0; m_q.delete(); m_addr = 0; m_count = 0;
      m_eimm = 0; m_ewrap = 0;
      return;
    end
    if (!m_valid) return;
    pop  = we_e && imem_ready;
    push = in_valid && rdy_e;
    if (pop) begin
      log_addr.push_back(32'(imem_addr));
      log_data.push_back(imem_wdata);
      void'(m_q.pop_front());
      if (m_addr == (1 << AW) - 1) m_ewrap = 1;
      m_addr  = (m_addr + 1) % (1 << AW);
      m_count = (m_count + 1) % (1 << (AW + 1));
    end
    if (push) begin
      w = enc(in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_alt, in_imm, e);
      m_q.push_back(w);
      if (e) m_eimm = 1;
    end
    case (m_phase)
      0: if (start) begin m_phase = 1; m_addr = 0; m_count = 0; m_eimm = 0; m_ewrap = 0; end
      1: if (push && in_last) m_phase = 2;
      2: if (m_q.size() == 0) m_phase = 3;
      default: m_phase = 0;
    endcase
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    if (rdy_hold > 0) begin imem_ready = 1'b0; rdy_hold--; end
    else if (rdy_mode == 0) imem_ready = 1'b1;
    else if (rdy_mode == 1) imem_ready = ($urandom % 4) != 0;
    else imem_ready = 1'b0;
  endtask

  task automatic add_b(input logic [3:0] k, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic alt, input logic [31:0] imm);
    bnd_t b;
    b.kind = k; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.f3 = f3; b.alt = alt; b.imm = imm;
    prog_q.push_back(b);
  endtask

  task automatic run_prog(input bit wait_done, input int hold, input bit rnd);
    int b;
    log_addr.delete(); log_data.delete(); done_cnt = 0; stall_cyc = 0;
    start = 1'b1; cyc(); start = 1'b0;
    rdy_hold = hold;
    foreach (prog_q[i]) begin
      if (rnd) begin
        in_valid = 1'b0;
        repeat ($urandom % 3) cyc();
        start = ($urandom % 6) == 0;
      end
      in_kind = prog_q[i].kind; in_rd = prog_q[i].rd; in_rs1 = prog_q[i].rs1;
      in_rs2 = prog_q[i].rs2; in_funct3 = prog_q[i].f3; in_alt = prog_q[i].alt;
      in_imm = prog_q[i].imm; in_last = (i == prog_q.size() - 1); in_valid = 1'b1;
      b = 0;
      while (!in_ready && b < 100) begin cyc(); b++; stall_cyc++; end
      if (b >= 100) begin chk("accept_timeout", 0, 1); in_valid = 1'b0; start = 1'b0; return; end
      cyc();
    end
    in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
    if (wait_done) begin
      b = 0;
      while (b < 300) begin cyc(); b++; if (done) break; end
      if (!done) chk("done_timeout", 0, 1);
      cyc();
    end
  endtask

  task automatic rand_bundle();
    int r, sel;
    logic [31:0] bnd[13];
    bnd_t b;
    bnd = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098, 1048574, -1048576,
            1048576, 31, 32};
    r = $urandom_range(0, 9);
    b.kind = (r == 9) ? 4'($urandom_range(9, 15)) : 4'(r);
    b.rd = 5'($urandom); b.rs1 = 5'($urandom); b.rs2 = 5'($urandom);
    b.f3 = 3'($urandom); b.alt = 1'($urandom);
    sel = $urandom % 5;
    case (sel)
      0: b.imm = 32'($urandom_range(0, 63)) - 32'd32;
      1: b.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      2: b.imm = bnd[$urandom % 13];
      3: b.imm = $urandom;
      default: b.imm = $urandom & 32'hFFFFF000;
    endcase
    prog_q.push_back(b);
  endtask

  initial begin
    int n;
    bit e;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_kind = '0; in_rd = '0; in_rs1 = '0;
    in_rs2 = '0; in_funct3 = '0; in_alt = 1'b0; in_imm = '0; in_last = 1'b0;
    imem_ready = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_done", done, 0);
    chk("rst_err_imm", err_imm, 0);
    chk("rst_err_wrap", err_wrap, 0);
    chk("rst_count", count, 0);

    // Hand-computed words pin the model.
    chk("pin_add", enc(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, e), 32'h002081B3);
    chk("pin_srai", enc(4'd1, 5'd5, 5'd6, 5'd0, 3'd5, 1'b1, 32'd3, e), 32'h40335293);
    chk("pin_beq", enc(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, -32'sd8, e), 32'hFE208CE3);

    // Known instruction words through the DUT.
    prog_q.delete();
    add_b(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0);
    add_b(4'd1, 5'd5, 5'd6, 5'd0, 3'd5, 1'b1, 32'd3);
    add_b(4'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd8);
    add_b(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, -32'sd8);
    add_b(4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048);
    run_prog(1, 0, 0);
    chk("lit_n", log_data.size(), 5);
    if (log_data.size() == 5) begin
      chk("lit_add", log_data[0], 32'h002081B3);
      chk("lit_srai", log_data[1], 32'h40335293);
      chk("lit_sw", log_data[2], 32'h0020A423);
      chk("lit_beq", log_data[3], 32'hFE208CE3);
      chk("lit_jal", log_data[4], 32'h001000EF);
      for (int i = 0; i < 5; i++) chk("lit_addr", log_addr[i], i);
    end

    // Out-of-range addi becomes a NOP and sets the sticky error.
    prog_q.delete();
    add_b(4'd1, 5'd4, 5'd4, 5'd0, 3'd0, 1'b0, 32'd4096);
    run_prog(1, 0, 0);
    chk("nop_word", (log_data.size() > 0) ? log_data[0] : 32'hX, 32'h00000013);
    repeat (3) cyc();
    chk("err_imm_held", err_imm, 1);
    prog_q.delete();
    add_b(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0);
    run_prog(1, 0, 0);
    chk("err_imm_cleared", err_imm, 0);

    // Six back-to-back bundles with memory stalled for the first cycles.
    prog_q.delete();
    for (int i = 0; i < 6; i++) add_b(4'd1, 5'(i + 1), 5'd0, 5'd0, 3'd0, 1'b0, 32'(i));
    run_prog(1, 3, 0);
    chk("bp_stall_seen", stall_cyc > 0, 1);
    chk("bp_count", count, 6);
    chk("bp_done_pulses", done_cnt, 1);
    chk("bp_n", log_addr.size(), 6);
    if (log_addr.size() == 6)
      for (int i = 0; i < 6; i++) chk("bp_addr", log_addr[i], i);

    // Reset while draining with two words buffered.
    rdy_mode = 2;
    prog_q.delete();
    add_b(4'd0, 5'd1, 5'd2, 5'd3, 3'd0, 1'b0, 32'd0);
    add_b(4'd0, 5'd4, 5'd5, 5'd6, 3'd0, 1'b0, 32'd0);
    run_prog(0, 0, 0);
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("rst_drain_we", imem_we, 0);
    chk("rst_drain_ready", in_ready, 0);
    rdy_mode = 0;
    repeat (4) cyc();
    chk("rst_drain_nowrite", log_data.size(), 0);

    // Address wrap: ninth word lands at address 0 with an 8-entry space.
    prog_q.delete();
    for (int i = 0; i < 9; i++) add_b(4'd1, 5'd1, 5'd1, 5'd0, 3'd0, 1'b0, 32'd1);
    run_prog(1, 0, 0);
    chk("wrap_flag", err_wrap, 1);
    chk("wrap_addr", (log_addr.size() == 9) ? log_addr[8] : 32'hX, 0);

    // Randomized programs.
    for (int p = 0; p < 40; p++) begin
      prog_q.delete();
      n = $urandom_range(1, 12);
      repeat (n) rand_bundle();
      rdy_mode = (p % 3 == 0) ? 0 : 1;
      run_prog(1, 0, 1);
      chk("rand_count", count, n);
      chk("rand_wrap", err_wrap, n >= 8);
    end
    rdy_mode = 0;
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
